// File: rtl/riscv_fetch_align_if.sv
// riscv_fetch_align_if: fetch-side and decode-side handshakes of the instruction aligner
//  fch_vld/fch_rdy/fch_dat : fetch word stream (parcel 0 = bits [15:0])
//  ins_vld/ins_rdy         : decoded-length instruction handshake
//  ins_dat/ins_siz/ins_ill : right-aligned instruction, size in bytes, illegal-length flag
//  slave modport = aligner view, master modport = fetch unit / decoder view
interface riscv_fetch_align_if #(
   parameter int FW   = 32,
   parameter int ILEN = 32
);
   logic            fch_vld;
   logic            fch_rdy;
   logic [FW-1:0]   fch_dat;
   logic            ins_vld;
   logic            ins_rdy;
   logic [ILEN-1:0] ins_dat;
   logic [3:0]      ins_siz;
   logic            ins_ill;
   modport master (output fch_vld, fch_dat, ins_rdy, input fch_rdy, ins_vld, ins_dat, ins_siz, ins_ill);
   modport slave  (input fch_vld, fch_dat, ins_rdy, output fch_rdy, ins_vld, ins_dat, ins_siz, ins_ill);
endinterface

// File: rtl/riscv_fetch_align.sv
// riscv_fetch_align: buffers 16-bit parcels from fetch words and emits one right-aligned instruction per handshake
//  clk       : clock
//  rst_n     : asynchronous active-low reset
//  flush     : drop all buffered parcels; flush_ofs parcels of the next fetch word are skipped
//  flush_ofs : parcel offset into the first fetch word after a flush
//  bus       : fetch/instruction handshakes (slave modport)
module riscv_fetch_align #(
   parameter int FW    = 32,
   parameter int ILEN  = 32,
   parameter int BUF_D = 8,
   localparam int OW   = FW > 16 ? $clog2(FW / 16) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [OW-1:0]      flush_ofs,
   riscv_fetch_align_if.slave bus
);
   localparam int NP = FW / 16;
   localparam int IP = ILEN / 16;
   localparam int CW = $clog2(BUF_D + 1);
   localparam int BW = $clog2(BUF_D);
   localparam int PW = NP > 1 ? $clog2(NP) : 1;
   if (BUF_D < NP + IP - 1) begin : g_bad_depth
      $error("riscv_fetch_align: BUF_D too small for FW/ILEN");
   end
   if (ILEN != 32 && ILEN != 48 && ILEN != 64) begin : g_bad_ilen
      $error("riscv_fetch_align: ILEN must be 32, 48 or 64");
   end
   if (FW % 16 != 0 || FW < 16 || FW > 128) begin : g_bad_fw
      $error("riscv_fetch_align: FW must be a multiple of 16 in 16..128");
   end
   logic [15:0]   buf_q [BUF_D];
   logic [15:0]   buf_d [BUF_D];
   logic [15:0]   fp [NP];
   logic [CW-1:0] count, count_d;
   logic [OW-1:0] skip;
   logic          rdy_en, push, pop, ill_raw;
   logic [3:0]    len, siz;
   int            pn, rem, sk;
   // len 0 stands for the reserved >=80-bit encodings
   always_comb begin
      len = buf_q[0][1:0] != 2'b11 ? 4'd2 : buf_q[0][4:2] != 3'b111 ? 4'd4 :
            !buf_q[0][5] ? 4'd6 : !buf_q[0][6] ? 4'd8 : 4'd0;
      ill_raw = len == 4'd0 || int'(len) * 8 > ILEN;
      siz = ill_raw ? 4'd2 : len;
   end
   assign bus.ins_siz = siz;
   assign bus.ins_ill = ill_raw && count != '0;
   assign bus.ins_vld = int'(count) >= int'(siz[3:1]);
   assign bus.fch_rdy = rdy_en && BUF_D - int'(count) >= NP;
   for (genvar i = 0; i < IP; i++) begin : g_dat
      assign bus.ins_dat[16*i +: 16] = int'(siz[3:1]) > i ? buf_q[i] : 16'h0;
   end
   for (genvar i = 0; i < NP; i++) begin : g_fp
      assign fp[i] = bus.fch_dat[16*i +: 16];
   end
   assign push = bus.fch_vld && bus.fch_rdy && !flush;
   assign pop  = bus.ins_vld && bus.ins_rdy && !flush;
   // surviving parcels shift down by the popped size; the new word lands right behind them
   always_comb begin
      pn  = pop ? int'(siz[3:1]) : 0;
      rem = int'(count) - pn;
      sk  = int'(skip);
      for (int j = 0; j < BUF_D; j++) begin
         buf_d[BW'(j)] = buf_q[BW'(j)];
         if (j < rem) buf_d[BW'(j)] = buf_q[BW'(j + pn)];
         else if (push && j - rem + sk < NP) buf_d[BW'(j)] = fp[PW'(j - rem + sk)];
      end
      count_d = flush ? '0 : CW'(rem + (push ? NP - sk : 0));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '{default: '0};
         count  <= '0;
         skip   <= '0;
         rdy_en <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         count  <= count_d;
         skip   <= flush ? flush_ofs : push ? '0 : skip;
         rdy_en <= 1'b1;
      end
   end
endmodule

// File: tb/tb_riscv_fetch_align.sv
// tb_riscv_fetch_align: scoreboard bench for riscv_fetch_align against a parcel-queue reference model
module tb_riscv_fetch_align;
   localparam int ILEN  = 32;
   localparam int BUF_D = 8;
   localparam int NP    = 2;
   typedef struct {
      logic [31:0] dat;
      logic [3:0]  siz;
      logic        ill;
      int          np;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [0:0]  flush_ofs = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] pend [$];
   exp_t        exp_q [$];
   int          mcount = 0, popped = 0, mskip = 0;
   bit          mrdy = 0, acc, hold = 0;
   logic [31:0] h_dat;
   logic [3:0]  h_siz;
   logic        h_ill;
   exp_t        e;
   riscv_fetch_align_if #(.FW(32), .ILEN(32)) bus ();
   riscv_fetch_align_if #(.FW(32), .ILEN(64)) b64 ();
   riscv_fetch_align #(.FW(32), .ILEN(32), .BUF_D(BUF_D)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .flush_ofs(flush_ofs), .bus(bus.slave));
   riscv_fetch_align #(.FW(32), .ILEN(64), .BUF_D(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .flush_ofs(1'b0), .bus(b64.slave));
   always #5 clk = ~clk;
   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endfunction
   // splits the pending parcel stream into whole instructions using the length rules
   function automatic void extract();
      logic [15:0] p;
      int          b;
      exp_t        x;
      while (pend.size() > 0) begin
         p = pend[0];
         b = p[1:0] != 2'b11 ? 2 : p[4:2] != 3'b111 ? 4 : !p[5] ? 6 : !p[6] ? 8 : 10;
         x.ill = b * 8 > ILEN;
         if (x.ill) b = 2;
         if (pend.size() < b / 2) break;
         x.siz = 4'(b);
         x.np  = b / 2;
         x.dat = '0;
         for (int i = 0; i < b / 2; i++) x.dat[16*i +: 16] = pend.pop_front();
         exp_q.push_back(x);
      end
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         exp_q.delete();
         mcount = 0;
         popped = 0;
         mskip  = 0;
         mrdy   = 0;
         hold   = 0;
      end else begin
         acc = bus.fch_vld && mrdy && BUF_D - mcount >= NP && !flush;
         mcount -= popped;
         popped = 0;
         if (flush) begin
            pend.delete();
            exp_q.delete();
            mcount = 0;
            mskip  = int'(flush_ofs);
         end else if (acc) begin
            for (int i = mskip; i < NP; i++) pend.push_back(bus.fch_dat[16*i +: 16]);
            mcount += NP - mskip;
            mskip = 0;
            extract();
         end
         mrdy = 1;
      end
   end
   always @(negedge clk) begin
      if (!rst_n) hold = 0;
      else begin
         chk("ins_vld", 64'(bus.ins_vld), 64'(exp_q.size() != 0));
         chk("fch_rdy", 64'(bus.fch_rdy), 64'(mrdy && BUF_D - mcount >= NP));
         if (!bus.ins_vld) chk("empty_ill", 64'(bus.ins_ill), 64'(0));
         if (hold) begin
            chk("stable_vld", 64'(bus.ins_vld), 64'(1));
            chk("stable_dat", 64'(bus.ins_dat), 64'(h_dat));
            chk("stable_siz", 64'(bus.ins_siz), 64'(h_siz));
            chk("stable_ill", 64'(bus.ins_ill), 64'(h_ill));
         end
         hold  = bus.ins_vld && !bus.ins_rdy && !flush;
         h_dat = bus.ins_dat;
         h_siz = bus.ins_siz;
         h_ill = bus.ins_ill;
         if (bus.ins_vld && bus.ins_rdy && !flush && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            popped = e.np;
            chk("ins_dat", 64'(bus.ins_dat), 64'(e.dat));
            chk("ins_siz", 64'(bus.ins_siz), 64'(e.siz));
            chk("ins_ill", 64'(bus.ins_ill), 64'(e.ill));
         end
      end
   end
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [31:0] w);
      bit ok = 0;
      bus.fch_vld = 1'b1;
      bus.fch_dat = w;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = bus.fch_rdy && !flush;
         @(posedge clk);
         #1;
      end
      bus.fch_vld = 1'b0;
      chk("send_accept", 64'(ok), 64'(1));
   endtask
   task automatic reset_checks();
      chk("rst_ins_vld", 64'(bus.ins_vld), 64'(0));
      chk("rst_fch_rdy", 64'(bus.fch_rdy), 64'(0));
      chk("rst_ins_siz", 64'(bus.ins_siz), 64'(2));
      chk("rst_ins_dat", 64'(bus.ins_dat), 64'(0));
      chk("rst_ins_ill", 64'(bus.ins_ill), 64'(0));
   endtask
   task automatic rand_phase(input int n);
      repeat (n) begin
         bus.fch_vld = $urandom_range(0, 3) != 0;
         bus.fch_dat = $urandom;
         bus.ins_rdy = $urandom_range(0, 3) != 0;
         flush       = $urandom_range(0, 49) == 0;
         flush_ofs   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
   endtask
   initial begin
      bus.fch_vld = 1'b0;
      bus.fch_dat = '0;
      bus.ins_rdy = 1'b0;
      b64.fch_vld = 1'b0;
      b64.fch_dat = '0;
      b64.ins_rdy = 1'b0;
      #1 reset_checks();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);
      b64.fch_vld = 1'b1;
      b64.fch_dat = 32'h1234001F;
      idle(1);
      chk("w64_partial_vld", 64'(b64.ins_vld), 64'(0));
      b64.fch_dat = 32'h00005678;
      idle(1);
      b64.fch_vld = 1'b0;
      chk("w64_vld", 64'(b64.ins_vld), 64'(1));
      chk("w64_dat", b64.ins_dat, 64'h0000_5678_1234_001F);
      chk("w64_siz", 64'(b64.ins_siz), 64'(6));
      chk("w64_ill", 64'(b64.ins_ill), 64'(0));
      b64.ins_rdy = 1'b1;
      idle(1);
      chk("w64_tail_vld", 64'(b64.ins_vld), 64'(1));
      chk("w64_tail_siz", 64'(b64.ins_siz), 64'(2));
      chk("w64_tail_dat", b64.ins_dat, 64'h0);
      b64.fch_vld = 1'b1;
      b64.fch_dat = 32'h0000007F;
      idle(1);
      b64.fch_vld = 1'b0;
      b64.ins_rdy = 1'b0;
      chk("w64_ill_flag", 64'(b64.ins_ill), 64'(1));
      chk("w64_ill_siz", 64'(b64.ins_siz), 64'(2));
      chk("w64_ill_dat", b64.ins_dat, 64'h7F);
      send(32'h00000013);
      bus.ins_rdy = 1'b1;
      idle(2);
      send(32'h45014501);
      idle(3);
      send(32'h00134501);
      send(32'h00000000);
      idle(3);
      send(32'h0000001F);
      idle(3);
      bus.ins_rdy = 1'b0;
      bus.fch_vld = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.fch_dat = {16'h4500 + 16'(8 * i + 4), 16'h4500 + 16'(8 * i)};
         if (i == 7) bus.ins_rdy = 1'b1;
         idle(1);
      end
      bus.fch_vld = 1'b0;
      idle(10);
      send(32'h00134501);
      idle(2);
      flush     = 1'b1;
      flush_ofs = 1'b1;
      idle(1);
      flush     = 1'b0;
      flush_ofs = 1'b0;
      send(32'h00134501);
      idle(2);
      send(32'h00000000);
      idle(3);
      rand_phase(1200);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 reset_checks();
      @(posedge clk);
      #1 rst_n = 1'b1;
      rand_phase(1200);
      bus.fch_vld = 1'b0;
      bus.ins_rdy = 1'b1;
      idle(20);
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
